// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: decode-side controls, program-memory bus and fetch outputs.
// The master modport is the surrounding core (decode + program memory); fetch_unit is the slave.
interface fetch_unit_if #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  logic            stall;
  logic            jump;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] jaddr;
  logic [15:0]     rd;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            ir_valid;
  logic [DW-1:0]   depth;
  logic            stack_ovf;
  logic            stack_unf;

  modport master (
    output stall, jump, call, ret, jaddr, rd,
    input  pc, ir, ir_valid, depth, stack_ovf, stack_unf
  );

  modport slave (
    input  stall, jump, call, ret, jaddr, rd,
    output pc, ir, ir_valid, depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, instruction register and return-address stack.
// Every taken jump/call/ret flushes ir_valid for exactly one cycle.
module fetch_unit #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.slave bus
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            irv_q, irv_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push;
  logic [AW-1:0]   top_idx;
  logic [PC_W-1:0] stack [STACK_DEPTH];

  // When depth is full the low bits wrap to zero, so subtracting one still lands on the top entry.
  assign top_idx = depth_q[AW-1:0] - AW'(1);

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!bus.stall) begin
      if (irv_q && bus.ret) begin
        irv_d = 1'b0;
        if (depth_q != '0) begin
          pc_d    = stack[top_idx];
          depth_d = depth_q - DW'(1);
        end else begin
          pc_d  = '0;
          unf_d = 1'b1;
        end
      end else if (irv_q && bus.call) begin
        irv_d = 1'b0;
        pc_d  = bus.jaddr;
        if (depth_q != FULL) begin
          push    = 1'b1;
          depth_d = depth_q + DW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (irv_q && bus.jump) begin
        irv_d = 1'b0;
        pc_d  = bus.jaddr;
      end else begin
        ir_d  = bus.rd;
        irv_d = 1'b1;
        pc_d  = pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents need no reset; depth alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) stack[depth_q[AW-1:0]] <= pc_q;
  end

  assign bus.pc        = pc_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = irv_q;
  assign bus.depth     = depth_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the simple CPU. Holds the program counter that addresses the program memory and latches the returned 16-bit word into an instruction register for decode. Supports jumps, subroutine calls and returns through an internal return-address stack, with stall and a one-bubble flush on every taken control transfer.

## Interface
- PC_W, 10: program counter width; matches the 1024-word program memory.
- STACK_DEPTH, 8: return-stack entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state while low.
- stall  in  1  freeze the stage: pc, ir, ir_valid and the stack hold.
- jump  in  1  load pc from jaddr.
- call  in  1  push return address, load pc from jaddr.
- ret  in  1  pop the stack into pc.
- jaddr  in  PC_W  jump/call target.
- rd  in  16  instruction word read from program memory at pc (combinational).
- pc  out  PC_W  fetch address to program memory.
- ir  out  16  registered instruction for decode.
- ir_valid  out  1  ir holds a real instruction (not a bubble).
- depth  out  clog2(STACK_DEPTH)+1  current stack occupancy, 0..STACK_DEPTH.
- stack_ovf  out  1  sticky: call issued with a full stack.
- stack_unf  out  1  sticky: ret issued with an empty stack.

## Operation
- Reset values: pc=0, ir=16'h0000, ir_valid=0, depth=0, stack_ovf=0, stack_unf=0; stack contents don't-care.
- jump/call/ret come from decode of ir; they are qualified by ir_valid. When ir_valid=0 they are ignored.
- Per-edge priority: stall > ret > call > jump > sequential.
- stall=1: nothing changes, including the sticky flags.
- Sequential: ir<=rd, ir_valid<=1, pc<=pc+1 modulo 2^PC_W (1023 wraps to 0).
- Invariant: when ir_valid=1 and no stall is pending, pc equals the address of ir plus 1. The return address is therefore the current pc.
- jump: pc<=jaddr, ir_valid<=0 (flush), ir holds its old value.
- call, stack not full: stack[depth]<=pc, depth<=depth+1, pc<=jaddr, ir_valid<=0.
- call, stack full: no push, depth unchanged, stack_ovf<=1; the jump is still taken with the same flush.
- ret, depth>0: pc<=stack[depth-1], depth<=depth-1, ir_valid<=0.
- ret, depth=0: pc<=0, stack_unf<=1, ir_valid<=0.
- Several of jump/call/ret asserted together: only the highest-priority one acts. For example, call+ret behaves as ret only.
- Sticky flags clear only on reset.
- reset asserted mid-operation: immediate asynchronous clear to the reset values; an in-flight flush or push is discarded.

## Timing
- Program memory is combinational, so rd is valid for pc within the same cycle.
- Fetch latency: one cycle from pc to ir.
- First instruction: mem[0] appears in ir with ir_valid=1 on the first rising edge after reset deasserts.
- Taken jump/call/ret costs exactly one bubble cycle (ir_valid=0). The target instruction appears in ir on the second edge after the control input is sampled.
- depth and the flags update on the same edge as the pc change.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset then free-run with mem[k]=k: ir takes 0,1,2,… with ir_valid=1 from edge 1; after 1024 edges pc wraps 1023→0 and ir shows word 1023 followed by word 0.
- Jump at ir address 5 with jaddr=0x100: next cycle ir_valid=0, pc=0x100; following cycle ir=mem[0x100], ir_valid=1, pc=0x101.
- Call at address 0x010 to 0x200, then ret at 0x203: depth goes 1→0; pc after ret is 0x011; one bubble after each transfer.
- Nine nested calls with STACK_DEPTH=8: depth saturates at 8 and stack_ovf=1 after the ninth; eight rets return in LIFO order; a ninth ret gives pc=0 and stack_unf=1.
- stall held for 3 cycles during a sequential run and also coincident with jump: pc, ir, ir_valid and depth are unchanged for all 3 cycles; the jump is applied only on the first cycle after stall drops.
- reset pulsed low asynchronously between edges while depth=3 and ir_valid=0: all outputs go to their reset values immediately, without waiting for a clock edge.
